add_arbiter: RTL and testbench
==============================

// Module: add_arbiter
// PURPOSE
//  Shares one add unit (1-cycle registered adder, valid/ack/res_valid/res_ready handshake)
//  between N_REQ requesters in the priority calculation datapath. Round-robin arbitration;
//  latches the granted operands, sequences one addition through the adder, and returns the
//  result to the granted requester with a per-requester valid/ready handshake.
// PARAMETERS
//  N_REQ  4   number of requesters (2..16)
//  WIDTH  64  operand/result width; must match the adder's WIDTH
// PORTS
//  clk            in   1            clock, all logic on rising edge
//  rst_n          in   1            asynchronous reset, active low
//  req_valid      in   N_REQ        requester i has operands pending
//  req_ready      out  N_REQ        one-hot pulse: operands of requester i accepted this cycle
//  req_a          in   N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b          in   N_REQ*WIDTH  operand B, same packing
//  rsp_valid      out  N_REQ        one-hot: result for requester i is on rsp_result
//  rsp_ready      in   N_REQ        requester i accepts its result
//  rsp_result     out  WIDTH        registered sum (a+b) mod 2^WIDTH
//  rsp_id         out  $clog2(N_REQ) index of requester owning rsp_result
//  add_valid      out  1            to adder: operands valid
//  add_a, add_b   out  WIDTH        to adder: latched operands
//  add_ack        in   1            from adder: operands taken (valid && res_ready)
//  add_result     in   WIDTH        from adder: sum
//  add_res_valid  in   1            from adder: sum valid (one cycle after add_valid)
//  add_res_ready  out  1            to adder: arbiter can take a result
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; req_ready, rsp_valid, add_valid, add_res_ready = 0;
//   add_a, add_b, rsp_result, rsp_id = 0; last-grant pointer = N_REQ-1 (requester 0 first).
//   Reset mid-operation abandons the operation; no response is ever issued for it.
//  FSM (registered state; outputs decoded from state/registers, no comb path in->out
//   except req_ready/grant decode in IDLE):
//   IDLE : if any req_valid: grant g = first set bit searching from last+1 upward, wrapping.
//          req_ready[g]=1 this cycle; latch req_a/req_b slice g into add_a/add_b, id<=g,
//          last<=g; -> ISSUE. No req_valid: stay, all req_ready=0.
//   ISSUE: add_valid=1, add_res_ready=1. On add_ack -> WAIT. No ack: hold, operands stable.
//   WAIT : add_valid=0, add_res_ready=0. On add_res_valid: rsp_result<=add_result -> RESP.
//          No add_res_valid: stay (adder contract guarantees it next cycle).
//   RESP : rsp_valid[id]=1, rsp_id=id, rsp_result stable. On rsp_ready[id] -> IDLE.
//          rsp_ready of other requesters ignored. Stall indefinitely while low.
//  Latency: handshake in IDLE at cycle T -> ISSUE T+1 -> WAIT T+2 -> rsp_valid high T+3
//   (with add_ack at T+1). Minimum 4 cycles per operation; new grant earliest the cycle
//   after rsp handshake.
//  Requester rules: req_valid held until req_ready; operands sampled only on req_ready
//   cycle, later changes ignored. A requester may re-request while its response pending;
//   it is not granted until RESP completes (single operation in flight).
//  Arithmetic: sum mod 2^WIDTH, carry discarded (adder-defined); no overflow flag.
//  Simultaneous requests: exactly one grant; fairness: each continuously requesting
//   requester granted within N_REQ operations. Single requester: granted every operation.
//  req_ready and rsp_valid always one-hot or zero; add_valid only in ISSUE.
// TESTING
//  1 req0: a=5,b=7 -> req_ready[0] pulse T, add_valid T+1, rsp_valid[0]=1,rsp_result=12,
//    rsp_id=0 at T+3.
//  2 all four req_valid held, rsp_ready=all 1, operands a=i,b=10 -> grant order 0,1,2,3,0,
//    results 10,11,12,13,10.
//  3 req1: a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> rsp_result=0, rsp_id=1.
//  4 rsp_ready low 20 cycles in RESP with req2 pending -> rsp_valid[0] and result held,
//    req_ready stays 0; release -> req2 granted the cycle after handshake.
//  5 rst_n low during WAIT -> all outputs 0 immediately; after release req1,req3 valid ->
//    req1 granted first (pointer reset), no stale response.
//  6 req2 only, 3 back-to-back ops; req_a changed after req_ready -> result uses sampled
//    values, every op granted to 2, spacing exactly 4 cycles.

Source files
------------

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one registered adder between N_REQ requesters.
// One operation in flight: grant, issue to adder, wait for sum, return to owner.
module add_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WIDTH-1:0]     req_a,
  input  logic [N_REQ*WIDTH-1:0]     req_b,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic [WIDTH-1:0]           rsp_result,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic                       add_valid,
  output logic [WIDTH-1:0]           add_a,
  output logic [WIDTH-1:0]           add_b,
  input  logic                       add_ack,
  input  logic [WIDTH-1:0]           add_result,
  input  logic                       add_res_valid,
  output logic                       add_res_ready
);

  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   last_q, last_d;

  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];
  logic             grant_vld;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   cand;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      a_arr[i] = req_a[i*WIDTH +: WIDTH];
      b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end
  end

  // Scan upward from the requester after the last grant, wrapping; first hit wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDW'((32'(last_q) + 32'(k) + 32'd1) % 32'(N_REQ));
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      add_a_q      <= '0;
      add_b_q      <= '0;
      rsp_result_q <= '0;
      id_q         <= '0;
      last_q       <= IDW'(N_REQ - 1);
    end else begin
      state_q      <= state_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      rsp_result_q <= rsp_result_d;
      id_q         <= id_d;
      last_q       <= last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    rsp_result_d = rsp_result_q;
    id_d         = id_q;
    last_d       = last_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          add_a_d = a_arr[grant_id];
          add_b_d = b_arr[grant_id];
          id_d    = grant_id;
          last_d  = grant_id;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: if (add_ack) state_d = S_WAIT;
      S_WAIT: begin
        if (add_res_valid) begin
          rsp_result_d = add_result;
          state_d      = S_RESP;
        end
      end
      S_RESP: if (rsp_ready[id_q]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // req_ready is the only input-to-output path; masked while reset is asserted.
  always_comb begin
    req_ready     = '0;
    rsp_valid     = '0;
    add_valid     = 1'b0;
    add_res_ready = 1'b0;
    case (state_q)
      S_IDLE:  if (grant_vld && rst_n) req_ready[grant_id] = 1'b1;
      S_ISSUE: begin
        add_valid     = 1'b1;
        add_res_ready = 1'b1;
      end
      S_RESP:  rsp_valid[id_q] = 1'b1;
      default: ;
    endcase
  end

  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign rsp_result = rsp_result_q;
  assign rsp_id     = id_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Bench for add_arbiter: behavioural 1-cycle adder, scoreboard of expected sums,
// table-driven single ops plus sequences for fairness, stall, reset and back-to-back.
module tb_add_arbiter;
  localparam int N = 4;
  localparam int W = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic [W-1:0]     rsp_result, add_a, add_b, add_result;
  logic [1:0]       rsp_id;
  logic             add_valid, add_ack, add_res_valid, add_res_ready;

  add_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_id(rsp_id),
    .add_valid(add_valid), .add_a(add_a), .add_b(add_b), .add_ack(add_ack),
    .add_result(add_result), .add_res_valid(add_res_valid), .add_res_ready(add_res_ready)
  );

  always #5 clk = ~clk;

  // Adder model: takes operands on valid && res_ready, presents the sum the next cycle.
  assign add_ack = add_valid && add_res_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_res_valid <= 1'b0;
      add_result    <= '0;
    end else begin
      add_res_valid <= add_ack;
      if (add_ack) add_result <= add_a + add_b;
    end
  end

  typedef struct { int id; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] exp; } vec_t;
  typedef struct { int id; logic [W-1:0] res; } sb_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  sb_t sb[$];
  int grant_log[$];
  int grant_cyc[$];
  logic [W-1:0] rsp_log[$];
  bit hold_req = 0;
  bit g_now, rsp_now, addv_seen, rspv_seen;
  int g_id, t_grant, t_addv, t_rspv, rsp_id_seen;
  logic [W-1:0] rsp_res_seen;
  vec_t vt[6];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    int g;
    logic [W-1:0] sum;
    logic [N-1:0] exp_v;
    g = 0;
    g_now = 0;
    rsp_now = 0;
    if (req_ready != '0) begin
      chk("req_ready_onehot", 64'($onehot(req_ready)), 64'd1);
      for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
      chk("grant_has_valid", 64'(req_valid[g]), 64'd1);
      g_now = 1; g_id = g; t_grant = cyc; addv_seen = 0; rspv_seen = 0;
      sum = req_a[g*W +: W] + req_b[g*W +: W];
      sb.push_back('{g, sum});
      grant_log.push_back(g);
      grant_cyc.push_back(cyc);
    end
    if (add_valid && !addv_seen) begin addv_seen = 1; t_addv = cyc; end
    if (rsp_valid != '0) begin
      if (!rspv_seen) begin rspv_seen = 1; t_rspv = cyc; end
      exp_v = '0;
      exp_v[rsp_id] = 1'b1;
      chk("rsp_valid_onehot", 64'(rsp_valid), 64'(exp_v));
      if (rsp_ready[rsp_id]) begin
        rsp_now = 1; rsp_id_seen = int'(rsp_id); rsp_res_seen = rsp_result;
        rsp_log.push_back(rsp_result);
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb_unexpected_rsp: got id %0d result %0h expected none", rsp_id, rsp_result);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("sb_id", 64'(rsp_id), 64'(e.id));
          chk("sb_result", rsp_result, e.res);
        end
      end
    end
  endtask

  // Sample mid-cycle, then move inputs just after the next rising edge.
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    if (g_now && !hold_req) req_valid[g_id] = 1'b0;
  endtask

  task automatic wait_grant(input int maxc, input string name);
    int n;
    n = 0;
    do begin cycle(); n++; end while (!g_now && n < maxc);
    if (!g_now) begin n_vec++; n_err++; $display("FAIL %s: no grant within %0d cycles", name, maxc); end
  endtask

  task automatic wait_rsp(input int maxc, input string name);
    int n;
    n = 0;
    do begin cycle(); n++; end while (!rsp_now && n < maxc);
    if (!rsp_now) begin n_vec++; n_err++; $display("FAIL %s: no response within %0d cycles", name, maxc); end
  endtask

  task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
  endtask

  initial begin
    vt[0] = '{0, 64'd5, 64'd7, 64'd12};
    vt[1] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
    vt[2] = '{3, 64'd100, 64'd200, 64'd300};
    vt[3] = '{2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 64'd1};
    vt[4] = '{0, 64'd0, 64'd0, 64'd0};
    vt[5] = '{1, 64'd123456789, 64'd987654321, 64'd1111111110};

    rst_n = 1'b0; req_valid = '1; rsp_ready = '1; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_add_valid", 64'(add_valid), 64'd0);
    chk("rst_add_res_ready", 64'(add_res_ready), 64'd0);
    chk("rst_add_a", add_a, 64'd0);
    chk("rst_rsp_result", rsp_result, 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    req_valid = '0;
    rst_n = 1'b1;

    // Single operations with latency checks
    foreach (vt[i]) begin
      set_req(vt[i].id, vt[i].a, vt[i].b);
      req_valid[vt[i].id] = 1'b1;
      wait_grant(10, "vec_grant");
      chk("vec_grant_id", 64'(g_id), 64'(vt[i].id));
      wait_rsp(10, "vec_rsp");
      chk("vec_result", rsp_res_seen, vt[i].exp);
      chk("vec_rsp_id", 64'(rsp_id_seen), 64'(vt[i].id));
      chk("lat_add_valid", 64'(t_addv - t_grant), 64'd1);
      chk("lat_rsp_valid", 64'(t_rspv - t_grant), 64'd3);
    end

    // Round-robin with every requester holding valid; pointer ended on 1 above, so
    // park it on 3 with one more op to start the rotation at 0.
    set_req(3, 64'd1, 64'd1); req_valid[3] = 1'b1;
    wait_grant(10, "park_grant"); wait_rsp(10, "park_rsp");
    grant_log.delete(); rsp_log.delete();
    for (int i = 0; i < N; i++) set_req(i, 64'(i), 64'd10);
    hold_req = 1; req_valid = '1;
    for (int n = 0; n < 100 && rsp_log.size() < 5; n++) cycle();
    req_valid = '0; hold_req = 0;
    chk("rr_count", 64'(rsp_log.size()), 64'd5);
    if (rsp_log.size() >= 5 && grant_log.size() >= 5) begin
      int eo[5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) begin
        chk("rr_grant", 64'(grant_log[i]), 64'(eo[i]));
        chk("rr_result", rsp_log[i], 64'(eo[i] + 10));
      end
    end

    // Response stall with another request pending
    rsp_ready = 4'b1110;
    set_req(0, 64'd40, 64'd2); req_valid[0] = 1'b1;
    wait_grant(10, "stall_grant");
    set_req(2, 64'd3, 64'd4); req_valid[2] = 1'b1;
    for (int n = 0; n < 10 && !rspv_seen; n++) cycle();
    repeat (20) begin
      cycle();
      chk("stall_rsp_valid", 64'(rsp_valid), 64'b0001);
      chk("stall_result", rsp_result, 64'd42);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready[0] = 1'b1;
    cycle();
    chk("stall_release_hs", 64'(rsp_now), 64'd1);
    cycle();
    chk("stall_next_grant", 64'(g_now), 64'd1);
    chk("stall_next_id", 64'(g_id), 64'd2);
    rsp_ready = '1;
    wait_rsp(10, "stall_rsp2");
    chk("stall_result2", rsp_res_seen, 64'd7);

    // Reset during WAIT abandons the op and returns the pointer to requester 0
    set_req(1, 64'd1000, 64'd1); req_valid[1] = 1'b1;
    wait_grant(10, "rst_grant");
    cycle();
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_add_valid", 64'(add_valid), 64'd0);
    chk("midrst_add_res_ready", 64'(add_res_ready), 64'd0);
    chk("midrst_add_a", add_a, 64'd0);
    chk("midrst_add_b", add_b, 64'd0);
    chk("midrst_rsp_result", rsp_result, 64'd0);
    chk("midrst_rsp_id", 64'(rsp_id), 64'd0);
    sb.delete();
    set_req(1, 64'd7, 64'd8); set_req(3, 64'd20, 64'd22);
    req_valid = 4'b1010;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_grant(10, "postrst_grant1");
    chk("postrst_first_id", 64'(g_id), 64'd1);
    wait_rsp(10, "postrst_rsp1");
    chk("postrst_result1", rsp_res_seen, 64'd15);
    wait_grant(10, "postrst_grant2");
    chk("postrst_second_id", 64'(g_id), 64'd3);
    wait_rsp(10, "postrst_rsp2");
    chk("postrst_result2", rsp_res_seen, 64'd42);

    // Back-to-back ops from one requester; operands scrambled after each grant
    grant_log.delete(); grant_cyc.delete(); rsp_log.delete();
    hold_req = 1;
    set_req(2, 64'd100, 64'd50); req_valid[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_grant(10, "b2b_grant");
      set_req(2, 64'hDEAD_BEEF_0000_0000, 64'h1234);
      if (k == 2) req_valid[2] = 1'b0;
      cycle();
      set_req(2, 64'(101 + k), 64'd50);
    end
    hold_req = 0;
    for (int n = 0; n < 20 && rsp_log.size() < 3; n++) cycle();
    chk("b2b_count", 64'(rsp_log.size()), 64'd3);
    if (rsp_log.size() >= 3 && grant_cyc.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("b2b_id", 64'(grant_log[k]), 64'd2);
        chk("b2b_result", rsp_log[k], 64'(150 + k));
      end
      chk("b2b_spacing1", 64'(grant_cyc[1] - grant_cyc[0]), 64'd4);
      chk("b2b_spacing2", 64'(grant_cyc[2] - grant_cyc[1]), 64'd4);
    end

    repeat (3) cycle();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
